// File: rtl/time_set_pkg.sv
// time_set_pkg: mode encodings, default 50 MHz cycle constants and a counter-width helper
// shared by the time-setting controller and its key event detectors.
package time_set_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_SET_SEC = 2'd3
    } mode_e;

    localparam int DEF_TIMEOUT_CYC    = 500_000_000;
    localparam int DEF_BLINK_CYC      = 12_500_000;
    localparam int DEF_LONG_PRESS_CYC = 50_000_000;
    localparam int DEF_REPEAT_CYC     = 10_000_000;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_event.sv
// key_event: falling-edge press detector for one debounced, active-low key.
// The INC hold/auto-repeat counter is built only when KEY_REPEAT_EN is defined and REPEAT_EN = 1.
module key_event
    import time_set_pkg::*;
#(
    parameter bit REPEAT_EN      = 1'b0,
    parameter int LONG_PRESS_CYC = DEF_LONG_PRESS_CYC,
    parameter int REPEAT_CYC     = DEF_REPEAT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    input  logic i_hold_en,
    input  logic i_hold_clr,
    output logic o_press,
    output logic o_repeat
);

    localparam int HOLD_MAX = (LONG_PRESS_CYC > REPEAT_CYC) ? LONG_PRESS_CYC : REPEAT_CYC;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    logic r_prev;
    logic r_armed;

    // r_armed keeps a key that was held through reset silent until it has been released once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_prev <= i_key;
            if (i_key) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_press = r_armed & r_prev & ~i_key;

`ifdef KEY_REPEAT_EN
    if (REPEAT_EN) begin : g_hold
        logic              r_active;
        logic [HOLD_W-1:0] r_hold;
        logic              w_hold_stop;

        assign w_hold_stop = i_hold_clr | i_key | ~i_hold_en;

        // Press loads the long-press delay; each terminal count reloads the repeat interval
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_active <= 1'b0;
                r_hold   <= '0;
            end else if (w_hold_stop) begin
                r_active <= 1'b0;
                r_hold   <= '0;
            end else if (o_press) begin
                r_active <= 1'b1;
                r_hold   <= HOLD_W'(LONG_PRESS_CYC - 2);
            end else if (r_active) begin
                if (r_hold == '0) begin
                    r_hold <= HOLD_W'(REPEAT_CYC - 1);
                end else begin
                    r_hold <= r_hold - 1'b1;
                end
            end
        end

        assign o_repeat = r_active & ~w_hold_stop & (r_hold == '0);
    end else begin : g_no_hold
        assign o_repeat = 1'b0;
    end
`else
    assign o_repeat = 1'b0;
`endif

    logic w_unused_cfg;
    assign w_unused_cfg = ^{REPEAT_EN, i_hold_en, i_hold_clr, (HOLD_W > 0)};

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: MODE/INC button sequencer for the clock's time-setting UI (mode FSM,
// idle timeout, blink phase). Define KEY_REPEAT_EN to enable INC long-press auto-repeat.
//
// state        | meaning
// MODE_RUN     | clock running, INC ignored, blink off
// MODE_SET_HR  | editing hours, INC -> inc_hour
// MODE_SET_MIN | editing minutes, INC -> inc_min
// MODE_SET_SEC | seconds stopped, INC -> clr_sec
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC,
    parameter int BLINK_CYC      = DEF_BLINK_CYC,
    parameter int LONG_PRESS_CYC = DEF_LONG_PRESS_CYC,
    parameter int REPEAT_CYC     = DEF_REPEAT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [1:0] mode,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       run_en,
    output logic       blink
);

    localparam int TO_W = cnt_width(TIMEOUT_CYC);
    localparam int BL_W = cnt_width(BLINK_CYC);

    logic w_mode_ev;
    logic w_inc_press;
    logic w_inc_rpt;
    logic w_inc_ev;
    logic w_unused_mode_rpt;
    logic w_hold_en;
    logic w_hold_clr;
    logic w_timeout;
    logic w_state_chg;

    mode_e r_state;
    mode_e w_nxt_state;
    logic  r_inc_hour, r_inc_min, r_clr_sec, r_run_en;
    logic  w_nxt_inc_hour, w_nxt_inc_min, w_nxt_clr_sec, w_nxt_run_en;

    logic [TO_W-1:0] r_to_cnt;
    logic [BL_W-1:0] r_bl_cnt;
    logic            r_blink;

    key_event #(
        .REPEAT_EN      (1'b0),
        .LONG_PRESS_CYC (LONG_PRESS_CYC),
        .REPEAT_CYC     (REPEAT_CYC)
    ) u_key_mode (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_key      (key_mode),
        .i_hold_en  (1'b0),
        .i_hold_clr (1'b0),
        .o_press    (w_mode_ev),
        .o_repeat   (w_unused_mode_rpt)
    );

    key_event #(
        .REPEAT_EN      (1'b1),
        .LONG_PRESS_CYC (LONG_PRESS_CYC),
        .REPEAT_CYC     (REPEAT_CYC)
    ) u_key_inc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_key      (key_inc),
        .i_hold_en  (w_hold_en),
        .i_hold_clr (w_hold_clr),
        .o_press    (w_inc_press),
        .o_repeat   (w_inc_rpt)
    );

    assign w_hold_en   = (r_state == MODE_SET_HR) || (r_state == MODE_SET_MIN);
    assign w_hold_clr  = w_mode_ev | w_timeout;
    assign w_inc_ev    = w_inc_press | w_inc_rpt;
    assign w_timeout   = (r_state != MODE_RUN) && (r_to_cnt == '0);
    assign w_state_chg = (w_nxt_state != r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= MODE_RUN;
            r_inc_hour <= 1'b0;
            r_inc_min  <= 1'b0;
            r_clr_sec  <= 1'b0;
            r_run_en   <= 1'b1;
        end else begin
            r_state    <= w_nxt_state;
            r_inc_hour <= w_nxt_inc_hour;
            r_inc_min  <= w_nxt_inc_min;
            r_clr_sec  <= w_nxt_clr_sec;
            r_run_en   <= w_nxt_run_en;
        end
    end

    // MODE outranks INC in the same cycle; any key event outranks the timeout
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_inc_hour = 1'b0;
        w_nxt_inc_min  = 1'b0;
        w_nxt_clr_sec  = 1'b0;
        if (w_mode_ev) begin
            case (r_state)
                MODE_RUN:     w_nxt_state = MODE_SET_HR;
                MODE_SET_HR:  w_nxt_state = MODE_SET_MIN;
                MODE_SET_MIN: w_nxt_state = MODE_SET_SEC;
                default:      w_nxt_state = MODE_RUN;
            endcase
        end else if (w_inc_ev) begin
            case (r_state)
                MODE_SET_HR:  w_nxt_inc_hour = 1'b1;
                MODE_SET_MIN: w_nxt_inc_min  = 1'b1;
                MODE_SET_SEC: w_nxt_clr_sec  = 1'b1;
                default:      ;
            endcase
        end else if (w_timeout) begin
            w_nxt_state = MODE_RUN;
        end
        w_nxt_run_en = (w_nxt_state != MODE_SET_SEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_nxt_state == MODE_RUN) begin
            r_to_cnt <= '0;
        end else if (w_state_chg || w_mode_ev || w_inc_ev) begin
            r_to_cnt <= TO_W'(TIMEOUT_CYC - 1);
        end else begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bl_cnt <= '0;
            r_blink  <= 1'b0;
        end else if (w_nxt_state == MODE_RUN) begin
            r_bl_cnt <= '0;
            r_blink  <= 1'b0;
        end else if (w_state_chg) begin
            r_bl_cnt <= BL_W'(BLINK_CYC - 1);
            r_blink  <= 1'b1;
        end else if (r_bl_cnt == '0) begin
            r_bl_cnt <= BL_W'(BLINK_CYC - 1);
            r_blink  <= ~r_blink;
        end else begin
            r_bl_cnt <= r_bl_cnt - 1'b1;
        end
    end

    assign mode     = r_state;
    assign inc_hour = r_inc_hour;
    assign inc_min  = r_inc_min;
    assign clr_sec  = r_clr_sec;
    assign run_en   = r_run_en;
    assign blink    = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench for time_set_ctrl; expected pulses are queued with their
// cycle when a key is driven and matched as the DUT emits them. KEY_REPEAT_EN adds repeat pulses.
module tb_time_set_ctrl;

    localparam int K_HOUR = 0;
    localparam int K_MIN  = 1;
    localparam int K_SEC  = 2;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [1:0] mode;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    logic       run_en;
    logic       blink;

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t mon_e;
    int   mon_kind;

    time_set_ctrl #(
        .TIMEOUT_CYC    (100),
        .BLINK_CYC      (4),
        .LONG_PRESS_CYC (20),
        .REPEAT_CYC     (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .mode     (mode),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .clr_sec  (clr_sec),
        .run_en   (run_en),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse monitor: every pulse must match the head of the queue in kind and cycle
    always @(negedge clk) begin
        if (inc_hour || inc_min || clr_sec) begin
            check_eq("pulse_pending", (q.size() > 0), 1);
            check_eq("pulse_onehot", 32'(inc_hour) + 32'(inc_min) + 32'(clr_sec), 1);
            if (q.size() > 0) begin
                mon_e    = q.pop_front();
                mon_kind = inc_hour ? K_HOUR : (inc_min ? K_MIN : K_SEC);
                check_eq("pulse_kind", mon_kind, mon_e.kind);
                check_eq("pulse_cycle", cyc, mon_e.cyc);
            end
        end
        if (q.size() > 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            check_eq("pulse_missing", cyc, mon_e.cyc);
        end
    end

    task automatic press_mode(input int exp_mode);
        key_mode = 1'b0;
        @(negedge clk);
        check_eq("mode_step", mode, exp_mode);
        check_eq("run_en", run_en, (exp_mode != 3));
        check_eq("blink_restart", blink, (exp_mode != 0));
        repeat (2) @(negedge clk);
        key_mode = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_inc(input int kind);
        key_inc = 1'b0;
        if (kind >= 0) q.push_back('{kind, cyc + 1});
        repeat (3) @(negedge clk);
        key_inc = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "bench did not complete");
    end

    initial begin
        // Reset with both keys held low
        repeat (3) @(negedge clk);
        check_eq("rst_mode", mode, 0);
        check_eq("rst_run_en", run_en, 1);
        check_eq("rst_blink", blink, 0);
        check_eq("rst_pulses", {inc_hour, inc_min, clr_sec}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("held_mode", mode, 0);
        check_eq("held_run_en", run_en, 1);
        check_eq("held_blink", blink, 0);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        repeat (3) @(negedge clk);

        // Mode stepping with INC in every state
        press_mode(1);
        press_inc(K_HOUR);
        press_inc(K_HOUR);
        press_inc(K_HOUR);
        press_mode(2);
        press_inc(K_MIN);
        press_mode(3);
        press_inc(K_SEC);
        check_eq("sec_run_en", run_en, 0);
        press_mode(0);
        press_inc(-1);
        check_eq("run_mode", mode, 0);

        // Both keys fall together in SET_MIN: MODE wins, INC dropped
        press_mode(1);
        press_mode(2);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        @(negedge clk);
        check_eq("both_mode", mode, 3);
        check_eq("both_run_en", run_en, 0);
        repeat (2) @(negedge clk);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        repeat (3) @(negedge clk);
        press_mode(0);

        // Idle timeout from SET_HR with blink phase tracking
        key_mode = 1'b0;
        @(negedge clk);
        check_eq("to_enter", mode, 1);
        check_eq("to_blink0", blink, 1);
        for (int k = 1; k <= 100; k++) begin
            if (k == 3) key_mode = 1'b1;
            @(negedge clk);
            if (k < 100) begin
                check_eq("to_mode_hold", mode, 1);
                check_eq("to_blink", blink, ((k / 4) % 2 == 0));
            end else begin
                check_eq("to_mode_run", mode, 0);
                check_eq("to_blink_off", blink, 0);
                check_eq("to_run_en", run_en, 1);
            end
        end
        repeat (3) @(negedge clk);

        // Long INC hold in SET_MIN
        press_mode(1);
        press_mode(2);
        key_inc = 1'b0;
        q.push_back('{K_MIN, cyc + 1});
`ifdef KEY_REPEAT_EN
        for (int r = 20; r <= 40; r += 5) q.push_back('{K_MIN, cyc + r});
`endif
        repeat (40) @(negedge clk);
        key_inc = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("hold_mode", mode, 2);
        press_mode(3);
        press_mode(0);

        repeat (5) @(negedge clk);
        check_eq("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Sequences the digital clock's time-setting user interface from two debounced push-buttons: MODE and INC.
- Inputs come from the debouncer outputs: level signals, pressed = 0, already stable.
- Detects press events and steps a mode state machine (RUN, SET_HR, SET_MIN, SET_SEC).
- Issues single-cycle increment/clear pulses to the timekeeping counters, gates the seconds counter, and drives a display blink enable.

Parameters:
- TIMEOUT_CYC, 500000000: idle cycles in any SET state before automatic return to RUN (10 s at 50 MHz).
- BLINK_CYC, 12500000: half-period of blink toggle (2 Hz blink at 50 MHz).
- LONG_PRESS_CYC, 50000000: INC hold time before auto-repeat starts (KEY_REPEAT_EN only).
- REPEAT_CYC, 10000000: auto-repeat interval (KEY_REPEAT_EN only).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- key_mode  in  1  debounced MODE level, 0 = pressed.
- key_inc  in  1  debounced INC level, 0 = pressed.
- mode  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.
- inc_hour  out  1  one-cycle pulse: hour counter +1.
- inc_min  out  1  one-cycle pulse: minute counter +1.
- clr_sec  out  1  one-cycle pulse: seconds counter cleared to 0.
- run_en  out  1  seconds counter enable.
- blink  out  1  display blink phase for the field being edited.

Behaviour:
- Reset (async, rst_n = 0):
  - State RUN; all pulses 0; run_en = 1; blink = 0; all counters 0.
  - Previous-key registers = 1 (released), so a key held low through reset release produces no event.
- Press event: a key's registered previous value is 1 and its current sample is 0. Release produces no event.
  - Outputs are registered: a pulse asserts in the cycle after the first low sample, for exactly 1 cycle.
- MODE event: RUN→SET_HR→SET_MIN→SET_SEC→RUN; the new mode is visible 1 cycle after the low sample.
- INC event by state:
  - SET_HR → inc_hour.
  - SET_MIN → inc_min.
  - SET_SEC → clr_sec.
  - RUN → ignored.
- Simultaneous MODE and INC events in the same cycle: MODE is processed, INC is discarded (no pulse).
- run_en = 0 only in SET_SEC; 1 otherwise. Registered together with mode.
- Idle timeout: counter runs only in SET states and clears on any key event, any state change, or entry to RUN.
  - Reaching TIMEOUT_CYC-1 forces RUN on the next edge.
  - A key event in the same cycle wins: the event is processed and the counter clears.
- Blink: counter runs in SET states; blink toggles every BLINK_CYC cycles.
  - In RUN, blink = 0 and the counter is held at 0.
  - Each state change restarts the counter with blink = 1.
- Counter widths: $clog2(param+1). Counters saturate/wrap only at their terminal count; they never overflow.
- Holding a key low produces no further events (without the optional feature). Another press requires a release of at least 1 cycle.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- With the macro defined:
  - While INC stays low in SET_HR or SET_MIN, a hold counter counts from the press event.
  - At LONG_PRESS_CYC, one extra inc_hour/inc_min pulse is issued, then one further pulse every REPEAT_CYC cycles until release.
  - The hold counter clears on release, on any MODE event, and on a timeout.
  - Repeat pulses also clear the idle timeout.
  - No repeat in SET_SEC or RUN.
- Without the macro: the hold logic is absent, and exactly one pulse is issued per press.

Decomposition:
- Package time_set_pkg:
  - mode encodings MODE_RUN/MODE_SET_HR/MODE_SET_MIN/MODE_SET_SEC (2-bit);
  - default cycle constants for 50 MHz.
- Sub-module key_event: per-key sample register, falling-edge detect, optional hold/repeat counter. Instantiated twice (repeat disabled for MODE).
- The FSM and timeout/blink counters stay in the top module.

Test Plan (sim parameters TIMEOUT_CYC=100, BLINK_CYC=4, LONG_PRESS_CYC=20, REPEAT_CYC=5):
- Reset with both keys low, release rst_n, hold keys low 10 cycles → mode = 0, no pulses, run_en = 1.
- Four MODE presses (low 3 cycles, high 3 cycles) → mode steps 1,2,3,0, each 1 cycle after the low sample; run_en = 0 only while mode = 3.
- In SET_HR, press INC 3 times → exactly 3 single-cycle inc_hour pulses; in SET_SEC, one press → one clr_sec; in RUN, an INC press → no pulse.
- Both keys fall in the same cycle while in SET_MIN → mode = 2→3, no inc_min.
- Enter SET_HR, no keys for 100 cycles → mode = 0 on cycle 100; blink toggles every 4 cycles before that and is 0 after.
- KEY_REPEAT_EN: hold INC low 40 cycles in SET_MIN → inc_min at cycles 1, 20, 25, 30, 35, 40 relative to the press; the release stops repeats.
